// File: rtl/acc_tile_sched_if.sv
`default_nettype none
// ============================================================================
// Module  : acc_tile_sched_if
// Purpose : Control/handshake bundle between the tile-loop scheduler and its
//           GLB / systolic-array / drain neighbours.
// Revision: 1.0
// ============================================================================
interface acc_tile_sched_if #(
  parameter int PE_SIZE        = 4,
  parameter int FIFO_DEPTH     = 4,
  parameter int WEIGHT_ROW_NUM = 294,
  parameter int WEIGHT_COL_NUM = 70
);
  localparam int ROW_TILES = (WEIGHT_ROW_NUM + PE_SIZE - 1) / PE_SIZE;
  localparam int COL_TILES = (WEIGHT_COL_NUM + PE_SIZE - 1) / PE_SIZE;
  localparam int BMAX      = (PE_SIZE > FIFO_DEPTH) ? PE_SIZE : FIFO_DEPTH;
  localparam int RW        = (ROW_TILES > 1) ? $clog2(ROW_TILES) : 1;
  localparam int CW        = (COL_TILES > 1) ? $clog2(COL_TILES) : 1;
  localparam int BW        = (BMAX > 1) ? $clog2(BMAX) : 1;

  logic          start_i;
  logic          glb_ready_i;
  logic          drain_ready_i;
  logic          busy_o;
  logic          done_o;
  logic          acc_clr_o;
  logic          w_load_o;
  logic          ifmap_en_o;
  logic          drain_valid_o;
  logic [BW-1:0] beat_idx_o;
  logic [RW-1:0] row_tile_o;
  logic [CW-1:0] col_tile_o;

  // Scheduler side
  modport master (
    input  start_i, glb_ready_i, drain_ready_i,
    output busy_o, done_o, acc_clr_o, w_load_o, ifmap_en_o, drain_valid_o,
           beat_idx_o, row_tile_o, col_tile_o
  );

  // Environment side
  modport slave (
    output start_i, glb_ready_i, drain_ready_i,
    input  busy_o, done_o, acc_clr_o, w_load_o, ifmap_en_o, drain_valid_o,
           beat_idx_o, row_tile_o, col_tile_o
  );
endinterface
`default_nettype wire

// File: rtl/acc_tile_sched.sv
`default_nettype none
// ============================================================================
// Module  : acc_tile_sched
// Purpose : Sequences weight loads, ifmap streaming, SA flush and ofmap drain
//           over every row/column tile of one weight matrix.
// Revision: 1.0
// ============================================================================
module acc_tile_sched #(
  parameter int PE_SIZE        = 4,
  parameter int FIFO_DEPTH     = 4,
  parameter int WEIGHT_ROW_NUM = 294,
  parameter int WEIGHT_COL_NUM = 70,
  parameter int SA_LATENCY     = 8
) (
  input  wire logic         clk,
  input  wire logic         rst,
  acc_tile_sched_if.master  bus
);
  localparam int ROW_TILES = (WEIGHT_ROW_NUM + PE_SIZE - 1) / PE_SIZE;
  localparam int COL_TILES = (WEIGHT_COL_NUM + PE_SIZE - 1) / PE_SIZE;
  localparam int BMAX      = (PE_SIZE > FIFO_DEPTH) ? PE_SIZE : FIFO_DEPTH;
  localparam int RW        = (ROW_TILES > 1) ? $clog2(ROW_TILES) : 1;
  localparam int CW        = (COL_TILES > 1) ? $clog2(COL_TILES) : 1;
  localparam int BW        = (BMAX > 1) ? $clog2(BMAX) : 1;
  localparam int WW        = (SA_LATENCY > 1) ? $clog2(SA_LATENCY) : 1;

  localparam logic [BW-1:0] PE_LAST   = BW'(PE_SIZE - 1);
  localparam logic [BW-1:0] FD_LAST   = BW'(FIFO_DEPTH - 1);
  localparam logic [RW-1:0] ROW_LAST  = RW'(ROW_TILES - 1);
  localparam logic [CW-1:0] COL_LAST  = CW'(COL_TILES - 1);
  localparam logic [WW-1:0] WAIT_LAST = WW'(SA_LATENCY - 1);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_CLR    = 3'd1,
    S_LOAD_W = 3'd2,
    S_STREAM = 3'd3,
    S_WAIT   = 3'd4,
    S_DRAIN  = 3'd5,
    S_DONE   = 3'd6
  } state_t;

  state_t        state_q, state_d;
  logic [BW-1:0] beat_q,  beat_d;
  logic [RW-1:0] row_q,   row_d;
  logic [CW-1:0] col_q,   col_d;
  logic [WW-1:0] wait_q,  wait_d;

  always_comb begin
    state_d = state_q;
    beat_d  = beat_q;
    row_d   = row_q;
    col_d   = col_q;
    wait_d  = wait_q;
    case (state_q)
      S_IDLE: begin
        if (bus.start_i) begin
          state_d = S_CLR;
          beat_d  = '0;
          row_d   = '0;
          col_d   = '0;
          wait_d  = '0;
        end
      end
      S_CLR: state_d = S_LOAD_W;
      S_LOAD_W: begin
        if (bus.glb_ready_i) begin
          if (beat_q == PE_LAST) begin
            beat_d  = '0;
            state_d = S_STREAM;
          end else begin
            beat_d = beat_q + BW'(1);
          end
        end
      end
      S_STREAM: begin
        if (bus.glb_ready_i) begin
          if (beat_q == FD_LAST) begin
            beat_d = '0;
            if (row_q == ROW_LAST) begin
              state_d = S_WAIT;
              wait_d  = '0;
            end else begin
              row_d   = row_q + RW'(1);
              state_d = S_LOAD_W;
            end
          end else begin
            beat_d = beat_q + BW'(1);
          end
        end
      end
      // Fixed flush: the last psums are still in flight through the array.
      S_WAIT: begin
        if (wait_q == WAIT_LAST) begin
          wait_d  = '0;
          state_d = S_DRAIN;
        end else begin
          wait_d = wait_q + WW'(1);
        end
      end
      S_DRAIN: begin
        if (bus.drain_ready_i) begin
          if (beat_q == FD_LAST) begin
            beat_d = '0;
            if (col_q == COL_LAST) begin
              state_d = S_DONE;
            end else begin
              col_d   = col_q + CW'(1);
              row_d   = '0;
              state_d = S_CLR;
            end
          end else begin
            beat_d = beat_q + BW'(1);
          end
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      beat_q  <= '0;
      row_q   <= '0;
      col_q   <= '0;
      wait_q  <= '0;
    end else begin
      state_q <= state_d;
      beat_q  <= beat_d;
      row_q   <= row_d;
      col_q   <= col_d;
      wait_q  <= wait_d;
    end
  end

  // Only the beat strobes see the ready inputs; everything else is pure state.
  assign bus.busy_o        = (state_q != S_IDLE);
  assign bus.done_o        = (state_q == S_DONE);
  assign bus.acc_clr_o     = (state_q == S_CLR);
  assign bus.w_load_o      = (state_q == S_LOAD_W) && bus.glb_ready_i;
  assign bus.ifmap_en_o    = (state_q == S_STREAM) && bus.glb_ready_i;
  assign bus.drain_valid_o = (state_q == S_DRAIN);
  assign bus.beat_idx_o    = ((state_q == S_LOAD_W) || (state_q == S_STREAM) ||
                              (state_q == S_DRAIN)) ? beat_q : '0;
  assign bus.row_tile_o    = row_q;
  assign bus.col_tile_o    = col_q;
endmodule
`default_nettype wire

// File: tb/tb_acc_tile_sched.sv
`default_nettype none
// ============================================================================
// Module  : tb_acc_tile_sched
// Purpose : Self-checking bench; compares the scheduler against a flat
//           per-cycle job schedule under random GLB/drain readiness.
// Revision: 1.0
// ============================================================================
module tb_acc_tile_sched;
  localparam int PE_SIZE        = 2;
  localparam int FIFO_DEPTH     = 3;
  localparam int WEIGHT_ROW_NUM = 3;
  localparam int WEIGHT_COL_NUM = 4;
  localparam int SA_LATENCY     = 2;
  localparam int RT = (WEIGHT_ROW_NUM + PE_SIZE - 1) / PE_SIZE;
  localparam int CT = (WEIGHT_COL_NUM + PE_SIZE - 1) / PE_SIZE;
  localparam int BW = 2;
  localparam int RW = 1;
  localparam int CW = 1;
  localparam int TILE_OPS = 1 + RT * (PE_SIZE + FIFO_DEPTH) + SA_LATENCY + FIFO_DEPTH;
  localparam int NOPS = CT * TILE_OPS + 1;
  localparam int OW = 6 + BW + RW + CW;
  localparam int K_CLR = 0, K_LOAD = 1, K_STREAM = 2, K_WAIT = 3, K_DRAIN = 4, K_DONE = 5;

  typedef struct { int kind; int beat; int row; int col; } op_t;
  op_t ops [NOPS];

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  acc_tile_sched_if #(.PE_SIZE(PE_SIZE), .FIFO_DEPTH(FIFO_DEPTH),
                      .WEIGHT_ROW_NUM(WEIGHT_ROW_NUM), .WEIGHT_COL_NUM(WEIGHT_COL_NUM)) bus ();

  acc_tile_sched #(.PE_SIZE(PE_SIZE), .FIFO_DEPTH(FIFO_DEPTH), .WEIGHT_ROW_NUM(WEIGHT_ROW_NUM),
                   .WEIGHT_COL_NUM(WEIGHT_COL_NUM), .SA_LATENCY(SA_LATENCY))
    dut (.clk(clk), .rst(rst), .bus(bus));

  // Model: a job is a flat list of one-cycle operations; a pointer walks it,
  // advancing whenever the readiness that gates the current operation is present.
  bit m_idle = 1'b1;
  int m_ptr = 0, m_row = 0, m_col = 0, cyc = 0, start_cyc = 0, m_starts = 0, m_dones = 0;

  function automatic bit op_advances(input op_t op);
    if (op.kind == K_LOAD || op.kind == K_STREAM) return bus.glb_ready_i;
    if (op.kind == K_DRAIN) return bus.drain_ready_i;
    return 1'b1;
  endfunction

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_idle = 1'b1; m_ptr = 0; m_row = 0; m_col = 0;
    end else begin
      cyc++;
      if (m_idle) begin
        if (bus.start_i) begin
          m_idle = 1'b0; m_ptr = 0; start_cyc = cyc; m_starts++;
        end
      end else if (op_advances(ops[m_ptr])) begin
        m_row = ops[m_ptr].row;
        m_col = ops[m_ptr].col;
        if (ops[m_ptr].kind == K_DONE) begin
          m_idle = 1'b1; m_dones++;
        end else begin
          m_ptr++;
        end
      end
    end
  end

  function automatic logic [OW-1:0] model_out();
    op_t op;
    int beat, row, col;
    logic done, clr, wl, ie, dv;
    {done, clr, wl, ie, dv} = '0;
    beat = 0; row = m_row; col = m_col;
    if (!m_idle) begin
      op   = ops[m_ptr];
      row  = op.row;
      col  = op.col;
      done = (op.kind == K_DONE);
      clr  = (op.kind == K_CLR);
      wl   = (op.kind == K_LOAD) && bus.glb_ready_i;
      ie   = (op.kind == K_STREAM) && bus.glb_ready_i;
      dv   = (op.kind == K_DRAIN);
      if (op.kind == K_LOAD || op.kind == K_STREAM || op.kind == K_DRAIN) beat = op.beat;
    end
    return {!m_idle, done, clr, wl, ie, dv, BW'(beat), RW'(row), CW'(col)};
  endfunction

  function automatic logic [OW-1:0] act_out();
    return {bus.busy_o, bus.done_o, bus.acc_clr_o, bus.w_load_o, bus.ifmap_en_o,
            bus.drain_valid_o, bus.beat_idx_o, bus.row_tile_o, bus.col_tile_o};
  endfunction

  int checks = 0, failures = 0;
  int n_wl, n_ie, n_dr, n_clr, n_done, done_off;
  int clr_off [2];
  int drain_hist [CT][FIFO_DEPTH];

  task automatic mon_clear();
    n_wl = 0; n_ie = 0; n_dr = 0; n_clr = 0; n_done = 0; done_off = -1;
    clr_off[0] = -1; clr_off[1] = -1;
    for (int c = 0; c < CT; c++) for (int b = 0; b < FIFO_DEPTH; b++) drain_hist[c][b] = 0;
  endtask

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s act=%0d exp=%0d t=%0t", name, act, exp, $time);
    end
  endtask

  // One clock: compare all outputs mid-cycle, gather event statistics, step.
  task automatic tick();
    logic [OW-1:0] e, a;
    @(negedge clk);
    e = model_out();
    a = act_out();
    checks++;
    if (a !== e) begin
      failures++;
      $display("FAIL cycle_outputs t=%0t act=%b exp=%b", $time, a, e);
    end
    if (bus.w_load_o === 1'b1) n_wl++;
    if (bus.ifmap_en_o === 1'b1) n_ie++;
    if (bus.acc_clr_o === 1'b1) begin
      if (n_clr < 2) clr_off[n_clr] = cyc - start_cyc + 1;
      n_clr++;
    end
    if (bus.done_o === 1'b1) begin
      done_off = cyc - start_cyc + 1;
      n_done++;
    end
    if (bus.drain_valid_o === 1'b1 && bus.drain_ready_i) begin
      n_dr++;
      if (int'(bus.beat_idx_o) < FIFO_DEPTH) drain_hist[bus.col_tile_o][bus.beat_idx_o]++;
    end
    @(posedge clk);
    #1;
  endtask

  // mode 0: readiness held; mode 1: drain_ready toggles every cycle
  task automatic wait_idle(input int mode, input int budget);
    int n = 0;
    while (!m_idle && n < budget) begin
      if (mode == 1) bus.drain_ready_i = ~bus.drain_ready_i;
      tick();
      n++;
    end
    chk("wait_idle_timeout", int'(m_idle), 1);
  endtask

  task automatic wait_op(input int kind, input int beat, input int col, input int budget);
    int n = 0;
    while (!(!m_idle && ops[m_ptr].kind == kind && ops[m_ptr].beat == beat &&
             ops[m_ptr].col == col) && n < budget) begin
      tick();
      n++;
    end
    chk("wait_op_timeout", int'(n < budget), 1);
  endtask

  task automatic pulse_start();
    bus.start_i = 1'b1;
    tick();
    bus.start_i = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog_timeout t=%0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    int k, s0;
    k = 0;
    for (int c = 0; c < CT; c++) begin
      ops[k] = '{K_CLR, 0, 0, c}; k++;
      for (int r = 0; r < RT; r++) begin
        for (int b = 0; b < PE_SIZE; b++) begin ops[k] = '{K_LOAD, b, r, c}; k++; end
        for (int b = 0; b < FIFO_DEPTH; b++) begin ops[k] = '{K_STREAM, b, r, c}; k++; end
      end
      for (int w = 0; w < SA_LATENCY; w++) begin ops[k] = '{K_WAIT, 0, RT - 1, c}; k++; end
      for (int b = 0; b < FIFO_DEPTH; b++) begin ops[k] = '{K_DRAIN, b, RT - 1, c}; k++; end
    end
    ops[k] = '{K_DONE, 0, RT - 1, CT - 1};
    mon_clear();

    // Reset with start held, then a quiet idle period
    rst = 1'b1;
    bus.start_i = 1'b1; bus.glb_ready_i = 1'b1; bus.drain_ready_i = 1'b1;
    repeat (5) tick();
    chk("reset_outputs", int'(act_out()), 0);
    rst = 1'b0;
    bus.start_i = 1'b0;
    repeat (20) tick();
    chk("idle_outputs", int'(act_out()), 0);

    // Nominal job without stalls
    mon_clear();
    pulse_start();
    wait_idle(0, 100);
    chk("nom_clr0_cycle", clr_off[0], 1);
    chk("nom_clr1_cycle", clr_off[1], 17);
    chk("nom_clr_count", n_clr, 2);
    chk("nom_wload_beats", n_wl, 8);
    chk("nom_ifmap_beats", n_ie, 12);
    chk("nom_drain_beats", n_dr, 6);
    chk("nom_done_cycle", done_off, 33);
    chk("nom_done_count", n_done, 1);

    // GLB stall of 5 cycles mid-STREAM
    mon_clear();
    pulse_start();
    wait_op(K_STREAM, 1, 0, 100);
    bus.glb_ready_i = 1'b0;
    #1;
    repeat (5) begin
      chk("stall_ifmap_en", int'(bus.ifmap_en_o), 0);
      chk("stall_beat_idx", int'(bus.beat_idx_o), 1);
      chk("stall_row_tile", int'(bus.row_tile_o), 0);
      tick();
    end
    bus.glb_ready_i = 1'b1;
    wait_idle(0, 100);
    chk("stall_done_cycle", done_off, 38);
    chk("stall_wload_beats", n_wl, 8);
    chk("stall_ifmap_beats", n_ie, 12);
    chk("stall_drain_beats", n_dr, 6);

    // Drain backpressure on alternate cycles
    mon_clear();
    pulse_start();
    wait_idle(1, 200);
    bus.drain_ready_i = 1'b1;
    for (int c = 0; c < CT; c++)
      for (int b = 0; b < FIFO_DEPTH; b++)
        chk($sformatf("bp_beat_c%0d_b%0d", c, b), drain_hist[c][b], 1);
    chk("bp_drain_beats", n_dr, 6);
    chk("bp_done_count", n_done, 1);

    // start held high through a whole job, including DONE
    mon_clear();
    s0 = m_starts;
    bus.start_i = 1'b1;
    begin
      int n = 0;
      while (m_starts < s0 + 2 && n < 200) begin tick(); n++; end
    end
    bus.start_i = 1'b0;
    chk("held_start_second_job", n_done, 1);
    wait_idle(0, 100);
    chk("held_start_done_count", n_done, 2);
    chk("held_start_done_cycle", done_off, 33);

    // Random readiness and random start pulses
    mon_clear();
    s0 = m_starts;
    repeat (400) begin
      bus.start_i       = ($urandom_range(0, 9) == 0);
      bus.glb_ready_i   = ($urandom_range(0, 9) < 7);
      bus.drain_ready_i = ($urandom_range(0, 9) < 6);
      tick();
    end
    bus.start_i = 1'b0; bus.glb_ready_i = 1'b1; bus.drain_ready_i = 1'b1;
    wait_idle(0, 200);
    chk("rand_done_per_start", n_done, m_starts - s0);

    // Reset during DRAIN of column tile 1, then a fresh job
    mon_clear();
    pulse_start();
    wait_op(K_DRAIN, 1, 1, 100);
    rst = 1'b1;
    #1;
    chk("rst_mid_outputs", int'(act_out()), 0);
    tick();
    chk("rst_mid_no_done", n_done, 0);
    rst = 1'b0;
    tick();
    mon_clear();
    pulse_start();
    chk("restart_acc_clr", int'(bus.acc_clr_o), 1);
    chk("restart_col_tile", int'(bus.col_tile_o), 0);
    chk("restart_row_tile", int'(bus.row_tile_o), 0);
    wait_idle(0, 100);
    chk("restart_done_count", n_done, 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
`default_nettype wire

// File: doc/acc_tile_sched.md
# acc_tile_sched

Tile-loop scheduler for the matrix-multiply unit. It sequences weight loads and ifmap streaming into the systolic array across all row tiles of one weight column tile. It clears the accumulation FIFOs at the start of each column tile, drains the finished ofmap column tile over a valid/ready handshake, and repeats until every column tile of the weight matrix is done. It sits between the GLB read side and the SA/accumulator datapath.

## Interface
- PE_SIZE, 4, systolic array dimension; beats per weight load.
- FIFO_DEPTH, 4, ifmap vectors streamed per row tile; equals accumulator FIFO depth and drain beats.
- WEIGHT_ROW_NUM, 294, weight matrix rows; ROW_TILES = ceil(WEIGHT_ROW_NUM/PE_SIZE).
- WEIGHT_COL_NUM, 70, weight matrix columns; COL_TILES = ceil(WEIGHT_COL_NUM/PE_SIZE).
- SA_LATENCY, 8, cycles (>=1) from the last ifmap beat until the final psum lands in the accumulator.
- Derived widths: RW = max(1,clog2(ROW_TILES)), CW = max(1,clog2(COL_TILES)), BW = max(1,clog2(max(PE_SIZE,FIFO_DEPTH))).

Ports (one clock domain; reset is asynchronous and active-high):
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- start_i  in  1  job start; sampled only in IDLE.
- glb_ready_i  in  1  GLB data available this cycle; gates load/stream beats.
- drain_ready_i  in  1  downstream accepts drain beat.
- busy_o  out  1  high in every state except IDLE.
- done_o  out  1  one-cycle pulse in DONE.
- acc_clr_o  out  1  one-cycle accumulator FIFO pointer clear (state CLR).
- w_load_o  out  1  weight load beat (LOAD_W && glb_ready_i).
- ifmap_en_o  out  1  ifmap stream beat (STREAM && glb_ready_i).
- beat_idx_o  out  BW  beat index within current LOAD_W/STREAM/DRAIN phase.
- row_tile_o  out  RW  current row tile.
- col_tile_o  out  CW  current column tile.
- drain_valid_o  out  1  drain beat valid (state DRAIN).

## Operation
- States: IDLE, CLR, LOAD_W, STREAM, WAIT, DRAIN, DONE.
- IDLE: start_i=1 -> CLR. row_tile=0, col_tile=0, beat=0.
- CLR (1 cycle): acc_clr_o=1 -> LOAD_W.
- LOAD_W: each cycle with glb_ready_i=1 is a beat; beat increments. Beat PE_SIZE-1 taken -> STREAM, beat=0.
- STREAM: same beat rule, FIFO_DEPTH beats. Last beat: if row_tile==ROW_TILES-1 -> WAIT, else row_tile++ and -> LOAD_W. beat=0 on exit.
- WAIT: counter runs SA_LATENCY cycles, unconditionally -> DRAIN.
- DRAIN: drain_valid_o=1; beat on drain_valid_o&&drain_ready_i; FIFO_DEPTH beats. Last beat: if col_tile==COL_TILES-1 -> DONE, else col_tile++, row_tile=0 -> CLR.
- DONE (1 cycle): done_o=1 -> IDLE.
- With glb_ready_i=0 or drain_ready_i=0, the state, beat, and tile indices hold. Beat outputs are low or valid stays high accordingly.
- start_i outside IDLE is ignored, including in DONE.
- Counters are compare-to-terminal and never wrap silently. Tile indices reset to 0 only at IDLE->CLR (both) or at column advance (row_tile).

## Timing
- Reset: state=IDLE, every counter 0. All outputs 0: busy_o, done_o, acc_clr_o, w_load_o, ifmap_en_o, drain_valid_o, beat_idx_o, row_tile_o, col_tile_o.
- Reset asserted mid-job: immediate return to IDLE with all outputs 0. No drain completion and no done_o.
- All outputs decode from registered state, counters, and the ready inputs. There is no other combinational input-to-output path.
- start_i sampled at edge N gives busy_o=1 and acc_clr_o=1 in cycle N+1.
- Without stalls, one column tile takes 1 + ROW_TILES*(PE_SIZE+FIFO_DEPTH) + SA_LATENCY + FIFO_DEPTH cycles. done_o follows the final drain beat by one cycle.
- beat_idx_o is valid alongside w_load_o, ifmap_en_o, and drain_valid_o, and is 0 in other states.

## Test plan
- Reset values: hold rst=1 then release, no start -> all outputs 0 for 20 cycles. start_i=1 while rst=1 -> no effect.
- Nominal job with PE_SIZE=2, FIFO_DEPTH=3, ROW=4, COL=4, SA_LATENCY=2, no stalls -> acc_clr_o at cycles 1 and 17; w_load_o beats=8; ifmap_en_o beats=12; drain beats=6; done_o at cycle 33 after the start edge.
- GLB stall: glb_ready_i=0 for 5 cycles mid-STREAM -> ifmap_en_o=0, beat_idx_o/row_tile_o frozen; total job 5 cycles longer; beat counts unchanged.
- Drain backpressure: drain_ready_i low on alternate cycles -> drain_valid_o held high; exactly FIFO_DEPTH accepted beats with beat_idx_o 0,1,2 each accepted once.
- start_i pulsed while busy and during DONE -> ignored; exactly one done_o per accepted start.
- rst asserted during DRAIN of col_tile=1 -> next cycle all outputs 0. A fresh start_i then replays from col_tile=0 with acc_clr_o.
